// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared FSM state type, default sizing constants and index-width helper for mult_scheduler
package mult_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;
    localparam int N_REQ_D   = 4;
    localparam int W_D       = 16;
    localparam int TIMEOUT_D = 15;
    localparam int GID_W     = $clog2(N_REQ_D);
    // Keeps index vectors at least one bit wide when only one requester exists.
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mult_scheduler_if.sv
// mult_scheduler_if: requester, multiplier and result-FIFO signals of the scheduler
//   master: scheduler side (drives pops, multiplier operands, pushes, status)
//   slave:  environment side (operand FIFOs, multiplier, result FIFOs)
interface mult_scheduler_if import mult_sched_pkg::*; #(
    parameter int N_REQ = N_REQ_D,
    parameter int W     = W_D
);
    localparam int IW = idx_w(N_REQ);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] op_a;
    logic [N_REQ*W-1:0] op_b;
    logic [N_REQ-1:0]   rd_req;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic               mul_start;
    logic               mul_done;
    logic [2*W-1:0]     mul_result;
    logic [N_REQ-1:0]   res_full;
    logic [N_REQ-1:0]   res_wr;
    logic [2*W-1:0]     res_data;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic               err_timeout;
    modport master (
        input  req, op_a, op_b, mul_done, mul_result, res_full,
        output rd_req, mul_a, mul_b, mul_start, res_wr, res_data, grant_id, busy, err_timeout
    );
    modport slave (
        output req, op_a, op_b, mul_done, mul_result, res_full,
        input  rd_req, mul_a, mul_b, mul_start, res_wr, res_data, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/mult_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr
//   req: request vector, ptr: starting index
//   gnt: one-hot winner, idx: winner index, valid: any request set
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);
    // Scanning from the farthest offset back to ptr leaves the nearest winner in idx.
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
        valid = |req;
        gnt = '0;
        gnt[idx] = valid;
    end
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin sharing of one multiplier among N_REQ operand/result FIFO pairs
//   clk, reset: clock and asynchronous active-high reset
//   bus: requester FIFOs, multiplier handshake, result FIFOs, grant/busy/timeout status
module mult_scheduler import mult_sched_pkg::*; #(
    parameter int N_REQ   = N_REQ_D,
    parameter int W       = W_D,
    parameter int TIMEOUT = TIMEOUT_D
) (
    input logic clk,
    input logic reset,
    mult_scheduler_if.master bus
);
    localparam int IW = idx_w(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, next;
    logic [N_REQ-1:0] elig, gnt, gnt_q;
    logic [IW-1:0] win, gid, rr, gid_inc;
    logic valid, err, timeout;
    logic [W-1:0] a, b;
    logic [2*W-1:0] res;
    logic [CW-1:0] cnt;
    // A requester whose result FIFO is full is skipped, so WRITE never needs a re-check.
    assign elig = bus.req & ~bus.res_full;
    rr_arbiter #(.N(N_REQ), .IW(IW)) arb (
        .req(elig), .ptr(rr), .gnt(gnt), .idx(win), .valid(valid)
    );
    assign timeout = state == WAIT && !bus.mul_done && cnt == CW'(TIMEOUT - 1);
    assign gid_inc = gid == IW'(N_REQ - 1) ? '0 : gid + 1'b1;
    assign bus.busy = state != IDLE;
    assign bus.mul_a = a;
    assign bus.mul_b = b;
    assign bus.res_data = res;
    assign bus.grant_id = gid;
    assign bus.err_timeout = err;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        bus.rd_req = '0;
        bus.res_wr = '0;
        bus.mul_start = 1'b0;
        case (state)
            IDLE:  if (valid) next = ISSUE;
            ISSUE: begin
                next = WAIT;
                bus.rd_req = gnt_q;
                bus.mul_start = 1'b1;
            end
            WAIT:  if (bus.mul_done) next = WRITE;
                   else if (timeout) next = IDLE;
            WRITE: begin
                next = IDLE;
                bus.res_wr = gnt_q;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            gid <= '0;
            gnt_q <= '0;
            rr <= '0;
            a <= '0;
            b <= '0;
            res <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == IDLE && valid) begin
                gid <= win;
                gnt_q <= gnt;
                a <= bus.op_a[win*W +: W];
                b <= bus.op_b[win*W +: W];
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT && !bus.mul_done) cnt <= cnt + 1'b1;
            if (state == WAIT && bus.mul_done) res <= bus.mul_result;
            if (timeout) err <= 1'b1;
            if (timeout || state == WRITE) rr <= gid_inc;
        end
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed checks of grant order, latency, back-pressure, timeout and reset abort
module tb_mult_scheduler;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int multi = 0;
    always #5 clk = ~clk;
    mult_scheduler_if #(.N_REQ(N), .W(W)) bus();
    mult_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    // Pulse counters and one-hot watch for the pop and push strobes.
    always @(negedge clk) begin
        rd_cnt += $countones(bus.rd_req);
        wr_cnt += $countones(bus.res_wr);
        if ($countones(bus.rd_req) > 1 || $countones(bus.res_wr) > 1) multi++;
    end

    task automatic clear_inputs();
        bus.req = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.mul_done = 1'b0;
        bus.mul_result = '0;
        bus.res_full = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for the issue of requester g, answers one cycle later with product p, checks the push.
    task automatic do_txn(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] p, input string nm);
        int n = 0;
        logic [N-1:0] oh = '0;
        oh[g] = 1'b1;
        while (bus.mul_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n == 20) begin
            errors++;
            $display("FAIL %s_issue_wait: mul_start never seen within 20 cycles", nm);
            return;
        end
        checks++;
        if (bus.rd_req !== oh) begin errors++; $display("FAIL %s_rd_req: got %b want %b", nm, bus.rd_req, oh); end
        checks++;
        if (bus.grant_id !== 2'(g)) begin errors++; $display("FAIL %s_grant_id: got %0d want %0d", nm, bus.grant_id, g); end
        checks++;
        if (bus.mul_a !== a || bus.mul_b !== b) begin
            errors++;
            $display("FAIL %s_operands: got %h,%h want %h,%h", nm, bus.mul_a, bus.mul_b, a, b);
        end
        @(negedge clk);
        bus.mul_done = 1'b1;
        bus.mul_result = p;
        @(negedge clk);
        bus.mul_done = 1'b0;
        checks++;
        if (bus.res_wr !== oh) begin errors++; $display("FAIL %s_res_wr: got %b want %b", nm, bus.res_wr, oh); end
        checks++;
        if (bus.res_data !== p) begin errors++; $display("FAIL %s_res_data: got %h want %h", nm, bus.res_data, p); end
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.req = 4'b1111;
        bus.op_a = {4{16'h1234}};
        bus.op_b = {4{16'h5678}};
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.err_timeout !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_status: busy=%b err=%b gid=%0d want 0,0,0", bus.busy, bus.err_timeout, bus.grant_id);
        end
        checks++;
        if (bus.rd_req !== 4'b0 || bus.res_wr !== 4'b0 || bus.mul_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: rd=%b wr=%b start=%b want 0", bus.rd_req, bus.res_wr, bus.mul_start);
        end
        checks++;
        if (bus.mul_a !== 16'h0 || bus.mul_b !== 16'h0 || bus.res_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h res=%h want 0", bus.mul_a, bus.mul_b, bus.res_data);
        end
    endtask

    task automatic test_single();
        int rd0, wr0;
        @(negedge clk);
        #1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        reset = 1'b0;
        bus.req = 4'b0001;
        bus.op_a = 64'h0003;
        bus.op_b = 64'h0002;
        @(negedge clk);
        checks++;
        if (bus.mul_start !== 1'b1 || bus.rd_req !== 4'b0001) begin
            errors++;
            $display("FAIL single_issue_latency: start=%b rd=%b want 1,0001", bus.mul_start, bus.rd_req);
        end
        checks++;
        if (bus.mul_a !== 16'h0003 || bus.mul_b !== 16'h0002) begin
            errors++;
            $display("FAIL single_operands: got %h,%h want 0003,0002", bus.mul_a, bus.mul_b);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        checks++;
        if (bus.mul_start !== 1'b0 || bus.rd_req !== 4'b0 || bus.mul_a !== 16'h0003 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: start=%b rd=%b a=%h busy=%b want 0,0000,0003,1",
                     bus.mul_start, bus.rd_req, bus.mul_a, bus.busy);
        end
        bus.mul_done = 1'b1;
        bus.mul_result = 32'h6;
        @(negedge clk);
        bus.mul_done = 1'b0;
        checks++;
        if (bus.res_wr !== 4'b0001 || bus.res_data !== 32'h00000006) begin
            errors++;
            $display("FAIL single_write: wr=%b res=%h want 0001,00000006", bus.res_wr, bus.res_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.res_wr !== 4'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b wr=%b want 0,0000", bus.busy, bus.res_wr);
        end
        checks++;
        if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin
            errors++;
            $display("FAIL single_pulse_count: rd=%0d wr=%0d want 1,1", rd_cnt - rd0, wr_cnt - wr0);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req = 4'b1111;
        bus.op_a = {16'd4, 16'd3, 16'd2, 16'd1};
        bus.op_b = {16'd40, 16'd30, 16'd20, 16'd10};
        do_txn(0, 16'd1, 16'd10, 32'd10, "rr0");
        do_txn(1, 16'd2, 16'd20, 32'd40, "rr1");
        do_txn(2, 16'd3, 16'd30, 32'd90, "rr2");
        do_txn(3, 16'd4, 16'd40, 32'd160, "rr3");
        do_txn(0, 16'd1, 16'd10, 32'd10, "rr0_again");
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_pressure();
        do_reset();
        bus.req = 4'b0011;
        bus.res_full = 4'b0001;
        bus.op_a = {16'd0, 16'd0, 16'd7, 16'd5};
        bus.op_b = {16'd0, 16'd0, 16'd9, 16'd11};
        do_txn(1, 16'd7, 16'd9, 32'd63, "bp_full");
        bus.res_full = 4'b0000;
        do_txn(0, 16'd5, 16'd11, 32'd55, "bp_freed");
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n = 0;
        int wr0;
        do_reset();
        bus.req = 4'b0100;
        bus.op_a = {16'd0, 16'd6, 16'd0, 16'd0};
        bus.op_b = {16'd0, 16'd7, 16'd0, 16'd0};
        while (bus.mul_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n == 20 || bus.rd_req !== 4'b0100) begin
            errors++;
            $display("FAIL to_issue: rd=%b after %0d cycles want 0100", bus.rd_req, n);
        end
        bus.req = 4'b0000;
        #1;
        wr0 = wr_cnt;
        repeat (TO) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_last_wait: busy=%b err=%b want 1,0", bus.busy, bus.err_timeout);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_expired: busy=%b err=%b want 0,1", bus.busy, bus.err_timeout);
        end
        #1;
        checks++;
        if (wr_cnt !== wr0) begin errors++; $display("FAIL to_no_write: got %0d pushes want 0", wr_cnt - wr0); end
        bus.req = 4'b1111;
        bus.op_a = {16'd8, 16'd0, 16'd0, 16'd0};
        bus.op_b = {16'd9, 16'd0, 16'd0, 16'd0};
        do_txn(3, 16'd8, 16'd9, 32'd72, "to_ptr_advanced");
        bus.req = 4'b0000;
        checks++;
        if (bus.err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", bus.err_timeout); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_max_operands();
        bus.req = 4'b0001;
        bus.op_a = 64'hFFFF;
        bus.op_b = 64'hFFFF;
        do_txn(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max");
        bus.req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_done();
        int wr0;
        #1;
        wr0 = wr_cnt;
        bus.mul_done = 1'b1;
        bus.mul_result = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        bus.mul_done = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || wr_cnt !== wr0 || bus.res_data !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL idle_done_ignored: busy=%b pushes=%0d res=%h want 0,0,fffe0001",
                     bus.busy, wr_cnt - wr0, bus.res_data);
        end
    endtask

    task automatic test_reset_in_wait();
        int n = 0;
        int wr0;
        bus.req = 4'b0010;
        bus.op_a = {16'd0, 16'd0, 16'd12, 16'd0};
        bus.op_b = {16'd0, 16'd0, 16'd13, 16'd0};
        while (bus.mul_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n == 20 || bus.rd_req !== 4'b0010) begin
            errors++;
            $display("FAIL rw_issue: rd=%b after %0d cycles want 0010", bus.rd_req, n);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.mul_start !== 1'b0 || bus.rd_req !== 4'b0 || bus.res_wr !== 4'b0) begin
            errors++;
            $display("FAIL rw_abort: busy=%b start=%b rd=%b wr=%b want 0", bus.busy, bus.mul_start, bus.rd_req, bus.res_wr);
        end
        checks++;
        if (bus.mul_a !== 16'h0 || bus.res_data !== 32'h0 || bus.err_timeout !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL rw_cleared: a=%h res=%h err=%b gid=%0d want 0", bus.mul_a, bus.res_data, bus.err_timeout, bus.grant_id);
        end
        wr0 = wr_cnt;
        @(negedge clk);
        reset = 1'b0;
        bus.mul_done = 1'b1;
        bus.mul_result = 32'd156;
        @(negedge clk);
        bus.mul_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wr_cnt !== wr0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rw_no_write: pushes=%0d busy=%b want 0,0", wr_cnt - wr0, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_timeout();
        test_max_operands();
        test_idle_done();
        test_reset_in_wait();
        checks++;
        if (multi !== 0) begin errors++; $display("FAIL strobe_onehot: %0d cycles with multiple bits want 0", multi); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 The block SHALL have these parameters: N_REQ, default 4, number of requester channels; W, default 16, operand width; TIMEOUT, default 15, maximum cycles to wait for a multiplier result.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req  in  N_REQ  bit i high means operand FIFO i is non-empty.
REQ-005 op_a  in  N_REQ*W  packed entry_1 operands; slice i belongs to requester i.
REQ-006 op_b  in  N_REQ*W  packed entry_2 operands; slice i belongs to requester i.
REQ-007 rd_req  out  N_REQ  one-cycle pop strobe to operand FIFO i.
REQ-008 mul_a, mul_b  out  W each  operands driven to the multiplier's entry_1/entry_2.
REQ-009 mul_start  out  1  one-cycle operand-valid strobe to the multiplier.
REQ-010 mul_done  in  1  multiplier result-valid strobe (its wr).
REQ-011 mul_result  in  2W  multiplier output_1.
REQ-012 res_full  in  N_REQ  bit i high means result FIFO i is full.
REQ-013 res_wr  out  N_REQ  one-cycle push strobe to result FIFO i.
REQ-014 res_data  out  2W  product written to the granted result FIFO.
REQ-015 grant_id  out  clog2(N_REQ)  index of the current or last granted requester.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 err_timeout  out  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and WRITE.
REQ-019 Requester i SHALL be eligible only when req[i]=1 and res_full[i]=0.
REQ-020 In IDLE, when any requester is eligible, the block SHALL select a winner round-robin starting at pointer rr_ptr, register that winner's op_a/op_b slices and its index, and move to ISSUE on the next edge.
REQ-021 In ISSUE, for exactly one cycle, the block SHALL assert rd_req[g] and mul_start, with mul_a/mul_b equal to the captured operands, then move to WAIT.
REQ-022 mul_a/mul_b SHALL hold the captured operands from ISSUE until the block leaves WAIT.
REQ-023 In WAIT, on mul_done=1 the block SHALL register mul_result into res_data and move to WRITE.
REQ-024 mul_done SHALL be ignored in every state except WAIT.
REQ-025 In WAIT, if mul_done stays low for TIMEOUT cycles, the block SHALL set err_timeout, write nothing and return to IDLE.
REQ-026 In WRITE, for exactly one cycle, the block SHALL assert res_wr[g] with res_data valid, then return to IDLE.
REQ-027 Because res_full[g]=0 was checked at grant and this block is the only writer, no full re-check SHALL occur in WRITE.
REQ-028 rr_ptr SHALL update to (g+1) mod N_REQ on leaving WRITE or on timeout.
REQ-029 If no requester is eligible, rr_ptr SHALL hold.
REQ-030 res_data SHALL be the unmodified 2W-bit product (no truncation); the maximum case is 0xFFFF*0xFFFF=0xFFFE0001.
REQ-031 At most one bit of rd_req and at most one bit of res_wr SHALL be high in any cycle.
REQ-032 Minimum latency SHALL be: eligible sampled at edge T, rd_req/mul_start during cycle T+1, res_wr no earlier than cycle T+3 (mul_done in cycle T+2).
REQ-033 The block SHALL issue no new grant while busy=1; a change of req during a transaction SHALL not affect that transaction.
REQ-034 err_timeout SHALL clear only on reset.

Reset
REQ-035 On reset the block SHALL go to IDLE with rr_ptr=0, grant_id=0, err_timeout=0, busy=0, and rd_req, res_wr and mul_start all 0.
REQ-036 On reset mul_a, mul_b and res_data SHALL be 0.
REQ-037 Reset asserted in any state, including mid-WAIT, SHALL abort the transaction with no res_wr pulse.
REQ-038 After release from reset, the first grant SHALL be evaluated at the first clk edge.

Structure
REQ-039 Shared package mult_sched_pkg SHALL hold the state enum, default N_REQ/W/TIMEOUT constants and the grant index width.
REQ-040 Round-robin selection SHALL be a separate sub-module, rr_arbiter: inputs request vector and pointer, outputs one-hot grant, index and a valid flag; purely combinational.
REQ-041 The timeout counter SHALL be clog2(TIMEOUT+1) bits and cleared on entry to WAIT.

Verification
REQ-042 Single request: req=0001, op_a[0]=0x0003, op_b[0]=0x0002, mul_done 1 cycle after mul_start -> rd_req=0001 once, res_wr=0001 once, res_data=0x00000006.
REQ-043 Round-robin: req=1111 held, 4 transactions -> grant order 0,1,2,3, then 0 again.
REQ-044 Back-pressure: req=0011, res_full=0001 -> only requester 1 is served; after res_full=0000, requester 0 is served next.
REQ-045 Timeout: mul_done never asserted -> after TIMEOUT cycles in WAIT, err_timeout=1, no res_wr, rr_ptr advanced.
REQ-046 Max operands 0xFFFF x 0xFFFF -> res_data=0xFFFE0001.
REQ-047 Reset pulsed during WAIT -> immediately busy=0, all strobes 0, no res_wr after release.
